vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- H_TOTAL, 800, nominal pixel clocks per line.
- H_SYNC, 96, hsync pulse width.
- H_BACKPORCH, 48, clocks from hsync end to first active pixel.
- H_DISPLAY, 640, active pixels per line.
- V_TOTAL, 525, nominal lines per frame.
- V_SYNC, 2, vsync width in lines.
- V_BACKPORCH, 33, lines from vsync end to first active line.
- V_DISPLAY, 480, active lines per frame.
- H_TOL, 1, permitted +/- deviation of measured line length.
- V_TOL, 1, permitted +/- deviation of measured frame length.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- pixelclk, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- hsync_in, in, 1, horizontal sync, active low, synchronous to pixelclk.
- vsync_in, in, 1, vertical sync, active low, synchronous to pixelclk.
- x_out, out, 10, active pixel column; 0 when not active.
- y_out, out, 10, active line; 0 when not active.
- active_out, out, 1, high while the current pixel is in the display window and locked.
- frame_start_out, out, 1, one-cycle pulse at the start of each locked frame.
- locked_out, out, 1, high while timing matches the parameters.
- err_out, out, 1, one-cycle pulse when lock is lost.

Function
REQ-003 hsync_in and vsync_in SHALL each pass through two flops: hs_q, hs_qq and vs_q, vs_qq.
REQ-004 hfall SHALL be defined as hs_qq=1 and hs_q=0.
REQ-005 hcnt (10 bit) SHALL load 0 on an hfall cycle; otherwise it SHALL increment, saturating at 1023.
REQ-006 On hfall, the measured line length SHALL equal the pre-load hcnt+1; the line is "good" when that length is within H_TOTAL+/-H_TOL.
REQ-007 On each hfall, vs_q SHALL be sampled into vs_line.
- vfall is defined as the previous vs_line=1 with the new sample 0.
REQ-008 On an hfall with vfall, vcnt (10 bit) SHALL load 0.
- On any other hfall it SHALL increment, saturating at 1023.
- It SHALL hold between hfalls.
REQ-009 On vfall, the measured frame length SHALL equal the pre-load vcnt+1; the frame is "good" when that length is within V_TOTAL+/-V_TOL.
REQ-010 The FSM SHALL have the states SEARCH, HMEAS, VMEAS and LOCKED.
REQ-011 SEARCH SHALL go to HMEAS on the first hfall.
REQ-012 HMEAS SHALL go to VMEAS after two consecutive good lines.
- A bad line SHALL restart the count in HMEAS.
REQ-013 VMEAS SHALL go to LOCKED on the first vfall.
- A bad line in VMEAS SHALL return the FSM to HMEAS.
REQ-014 LOCKED SHALL go to SEARCH on any of: a bad line, a bad frame, or hcnt reaching 1023 (hsync absent).
- err_out SHALL pulse high for exactly that one cycle.
REQ-015 In SEARCH, HMEAS and VMEAS, hcnt reaching 1023 SHALL return the FSM to SEARCH without err_out.
REQ-016 locked_out SHALL be a registered output, high exactly while the FSM is in LOCKED.
- It SHALL first rise on the cycle after the transitioning vfall, that is, on the first line of the new frame.
REQ-017 When locked, active_out SHALL be registered high when both of these hold:
- hcnt is in [H_SYNC+H_BACKPORCH, H_SYNC+H_BACKPORCH+H_DISPLAY-1] = [144,783];
- vcnt is in [V_SYNC+V_BACKPORCH, V_SYNC+V_BACKPORCH+V_DISPLAY-1] = [35,514].
REQ-018 x_out SHALL be hcnt-144 and y_out SHALL be vcnt-35 when active, both registered alongside active_out (one-cycle latency from hcnt/vcnt); both SHALL be 0 otherwise.
REQ-019 frame_start_out SHALL pulse for one cycle, registered, on each good vfall while in LOCKED.
- It SHALL also pulse on the VMEAS-to-LOCKED vfall.
REQ-020 When a bad frame and a good line coincide on the same hfall, loss of lock SHALL take priority.
- The FSM SHALL go to SEARCH, err_out SHALL pulse, and frame_start_out SHALL stay low.

Reset
REQ-021 While reset is high, the following SHALL hold immediately, independent of pixelclk:
- the FSM is in SEARCH;
- hcnt, vcnt, x_out and y_out are 0;
- active_out, frame_start_out, locked_out and err_out are 0;
- all sync flops and vs_line are 1 (the idle sync level).
REQ-022 A reset assertion mid-frame SHALL discard all measurement; after deassertion, lock SHALL require the full SEARCH-to-LOCKED sequence again.

Verification
REQ-023 Feed 3 nominal 800x525 frames (96/2 sync) -> locked_out rises at the start of frame 2, frame_start_out gives one pulse per frame from then on, and active_out is high for exactly 640x480 cycles per frame.
REQ-024 While locked, check the first and last active pixels -> x_out=0,y_out=0 at the first active pixel and x_out=639,y_out=479 at the last; active_out is low at hcnt 143 and at 784.
REQ-025 Use 801-clock lines (within H_TOL) -> lock is still acquired; then inject one 790-clock line -> err_out pulses once and locked_out drops, then returns after 2 good lines plus a vfall.
REQ-026 Hold hsync_in high for 1100 cycles while locked -> err_out pulses at hcnt=1023, the FSM enters SEARCH, and locked_out=0.
REQ-027 Deliver a 520-line frame while locked -> err_out pulses at that vfall, frame_start_out stays low, and locked_out=0.
REQ-028 Assert reset mid-line while locked -> all outputs are 0 within the same cycle; after release, no lock occurs before a full frame has been observed.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync timing decoder with lock detection and pixel coordinates
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BACKPORCH = 48,
    parameter int H_DISPLAY   = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_BACKPORCH = 33,
    parameter int V_DISPLAY   = 480,
    parameter int H_TOL       = 1,
    parameter int V_TOL       = 1
) (
    input  logic       pixelclk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic       active_out,
    output logic       frame_start_out,
    output logic       locked_out,
    output logic       err_out
);

    typedef enum logic [1:0] {SEARCH, HMEAS, VMEAS, LOCKED} state_t;

    localparam logic [10:0] H_LEN_MIN = 11'(H_TOTAL - H_TOL);
    localparam logic [10:0] H_LEN_MAX = 11'(H_TOTAL + H_TOL);
    localparam logic [10:0] V_LEN_MIN = 11'(V_TOTAL - V_TOL);
    localparam logic [10:0] V_LEN_MAX = 11'(V_TOTAL + V_TOL);
    localparam logic [9:0]  H_FIRST   = 10'(H_SYNC + H_BACKPORCH);
    localparam logic [9:0]  H_LAST    = 10'(H_SYNC + H_BACKPORCH + H_DISPLAY - 1);
    localparam logic [9:0]  V_FIRST   = 10'(V_SYNC + V_BACKPORCH);
    localparam logic [9:0]  V_LAST    = 10'(V_SYNC + V_BACKPORCH + V_DISPLAY - 1);
    localparam logic [9:0]  CNT_MAX   = 10'd1023;

    state_t      state, state_next;
    logic        good_cnt, good_cnt_next;
    logic        err_next, fs_next;
    logic        hs_q, hs_qq, vs_q, vs_qq, vs_line;
    logic [9:0]  hcnt, vcnt;
    logic [10:0] line_len, frame_len;
    logic        hfall, vfall, good_line, good_frame, timeout;
    logic        in_window;
    logic        sync_unused;

    // vs_qq completes the symmetric sync pipeline; only vs_q feeds the line sampler
    assign sync_unused = vs_qq;

    assign hfall      = hs_qq & ~hs_q;
    assign vfall      = hfall & vs_line & ~vs_q;
    assign line_len   = {1'b0, hcnt} + 11'd1;
    assign frame_len  = {1'b0, vcnt} + 11'd1;
    assign good_line  = (line_len >= H_LEN_MIN) && (line_len <= H_LEN_MAX);
    assign good_frame = (frame_len >= V_LEN_MIN) && (frame_len <= V_LEN_MAX);
    assign timeout    = (hcnt == CNT_MAX) && !hfall;
    assign in_window  = (hcnt >= H_FIRST) && (hcnt <= H_LAST) &&
                        (vcnt >= V_FIRST) && (vcnt <= V_LAST);

    // Two-flop sync pipelines, idle high
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            hs_q  <= 1'b1;
            hs_qq <= 1'b1;
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
        end else begin
            hs_q  <= hsync_in;
            hs_qq <= hs_q;
            vs_q  <= vsync_in;
            vs_qq <= vs_q;
        end
    end

    // Pixel counter restarts on each hsync falling edge, saturates when hsync is missing
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            hcnt <= 10'd0;
        end else if (hfall) begin
            hcnt <= 10'd0;
        end else if (hcnt != CNT_MAX) begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Line counter and per-line vsync sample, both advance only on hsync falling edges
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            vcnt    <= 10'd0;
            vs_line <= 1'b1;
        end else if (hfall) begin
            vs_line <= vs_q;
            if (vfall) begin
                vcnt <= 10'd0;
            end else if (vcnt != CNT_MAX) begin
                vcnt <= vcnt + 10'd1;
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
        end
    end

    // Lock FSM transitions; loss of lock wins over a coincident frame start
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        err_next      = 1'b0;
        fs_next       = 1'b0;
        case (state)
            SEARCH: begin
                if (hfall) begin
                    state_next    = HMEAS;
                    good_cnt_next = 1'b0;
                end
            end
            HMEAS: begin
                if (timeout) begin
                    state_next = SEARCH;
                end else if (hfall) begin
                    if (!good_line) begin
                        good_cnt_next = 1'b0;
                    end else if (good_cnt) begin
                        state_next    = VMEAS;
                        good_cnt_next = 1'b0;
                    end else begin
                        good_cnt_next = 1'b1;
                    end
                end
            end
            VMEAS: begin
                if (timeout) begin
                    state_next = SEARCH;
                end else if (hfall) begin
                    if (!good_line) begin
                        state_next    = HMEAS;
                        good_cnt_next = 1'b0;
                    end else if (vfall) begin
                        state_next = LOCKED;
                        fs_next    = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (timeout || (hfall && (!good_line || (vfall && !good_frame)))) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                end else if (vfall) begin
                    fs_next = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // Registered outputs: status pulses and display-window coordinates
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            locked_out      <= 1'b0;
            err_out         <= 1'b0;
            frame_start_out <= 1'b0;
            active_out      <= 1'b0;
            x_out           <= 10'd0;
            y_out           <= 10'd0;
        end else begin
            locked_out      <= (state_next == LOCKED);
            err_out         <= err_next;
            frame_start_out <= fs_next;
            if ((state == LOCKED) && in_window) begin
                active_out <= 1'b1;
                x_out      <= hcnt - H_FIRST;
                y_out      <= vcnt - V_FIRST;
            end else begin
                active_out <= 1'b0;
                x_out      <= 10'd0;
                y_out      <= 10'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - self-checking bench for vga_sync_decoder
module tb_vga_sync_decoder;

    localparam int H_T  = 40;
    localparam int H_S  = 4;
    localparam int H_BP = 6;
    localparam int H_D  = 24;
    localparam int V_T  = 20;
    localparam int V_S  = 2;
    localparam int V_BP = 3;
    localparam int V_D  = 12;
    localparam int TOL  = 1;
    localparam int HS0  = H_S + H_BP;
    localparam int VS0  = V_S + V_BP;

    logic       pixelclk = 1'b0;
    logic       reset    = 1'b1;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] x_out, y_out;
    logic       active_out, frame_start_out, locked_out, err_out;

    vga_sync_decoder #(
        .H_TOTAL(H_T), .H_SYNC(H_S), .H_BACKPORCH(H_BP), .H_DISPLAY(H_D),
        .V_TOTAL(V_T), .V_SYNC(V_S), .V_BACKPORCH(V_BP), .V_DISPLAY(V_D),
        .H_TOL(TOL), .V_TOL(TOL)
    ) dut (
        .pixelclk(pixelclk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x_out(x_out), .y_out(y_out), .active_out(active_out),
        .frame_start_out(frame_start_out), .locked_out(locked_out), .err_out(err_out)
    );

    always #5 pixelclk = ~pixelclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base_len = H_T;
    int last_len = H_T;
    int h1_p = 0, h1_l = 0, h2_p = 0, h2_l = 0;
    bit h1_chk = 0, h2_chk = 0;
    int act_cnt, fs_cnt, err_cnt, rise_cnt, rise_p, rise_l, err_cyc;
    int first_x, first_y, last_x, last_y;
    bit seen_act, prev_locked = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, 32'(active_out), 0);
        check({tag, "_x"}, 32'(x_out), 0);
        check({tag, "_y"}, 32'(y_out), 0);
        check({tag, "_fs"}, 32'(frame_start_out), 0);
        check({tag, "_locked"}, 32'(locked_out), 0);
        check({tag, "_err"}, 32'(err_out), 0);
    endtask

    task automatic clear_stats();
        act_cnt = 0; fs_cnt = 0; err_cnt = 0; rise_cnt = 0;
        rise_p = -1; rise_l = -1; err_cyc = -1; seen_act = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    endtask

    // One pixel clock: observe outputs of the edge just past, then drive the next input.
    // Expected window: hcnt = p-1 and vcnt = l for the input sampled one edge earlier.
    task automatic step(input logic h, input logic v, input int p, input int l,
                        input bit c, input int ctl);
        logic exp_act;
        @(negedge pixelclk);
        cyc++;
        if (h2_chk) begin
            exp_act = (h2_p >= HS0 + 1) && (h2_p <= HS0 + H_D) &&
                      (h2_l >= VS0) && (h2_l < VS0 + V_D);
            check("active", 32'(active_out), 32'(exp_act));
            check("x", 32'(x_out), exp_act ? 32'(h2_p - HS0 - 1) : 0);
            check("y", 32'(y_out), exp_act ? 32'(h2_l - VS0) : 0);
        end
        if (active_out) begin
            act_cnt++;
            if (!seen_act) begin
                first_x = int'(x_out); first_y = int'(y_out); seen_act = 1;
            end
            last_x = int'(x_out); last_y = int'(y_out);
        end
        if (frame_start_out) fs_cnt++;
        if (err_out) begin
            err_cnt++; err_cyc = cyc;
        end
        if (locked_out && !prev_locked) begin
            rise_cnt++; rise_p = h1_p; rise_l = h1_l;
        end
        prev_locked = locked_out;
        h2_p = h1_p; h2_l = h1_l; h2_chk = h1_chk;
        h1_p = p; h1_l = l; h1_chk = c;
        hsync_in = h;
        vsync_in = v;
        if (ctl == 1) begin
            reset = 1'b1;
            h1_chk = 0; h2_chk = 0;
            #1;
            check_all_zero("rst_mid");
        end else if (ctl == 2) begin
            reset = 1'b0;
        end
    endtask

    task automatic send_frame(input int nlines, input bit chk, input int bad_line,
                              input int bad_len, input bit rand_len,
                              input int rst_line, input int rst_p);
        int len;
        int ctl;
        bit after_rst;
        after_rst = 0;
        for (int l = 0; l < nlines; l++) begin
            if (l == bad_line) len = bad_len;
            else if (rand_len) len = int'($urandom_range(H_T + TOL, H_T - TOL));
            else len = base_len;
            last_len = len;
            for (int p = 0; p < len; p++) begin
                ctl = 0;
                if (l == rst_line && p == rst_p) begin
                    ctl = 1; after_rst = 1;
                end else if (l == rst_line && p == rst_p + 3) begin
                    ctl = 2;
                end
                step((p < H_S) ? 1'b0 : 1'b1, (l < V_S) ? 1'b0 : 1'b1, p, l,
                     chk && !after_rst, ctl);
            end
        end
    endtask

    task automatic nominal(input bit chk);
        send_frame(V_T, chk, -1, 0, 0, -1, 0);
    endtask

    task automatic do_reset();
        @(negedge pixelclk);
        reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        h1_chk = 0; h2_chk = 0;
        #1;
        check_all_zero("rst");
        repeat (3) @(negedge pixelclk);
        reset = 1'b0;
    endtask

    initial begin
        int g0;
        int bad_len;
        int rst_p;

        // reset state, asynchronous
        #1;
        check_all_zero("por");
        repeat (3) @(negedge pixelclk);
        reset = 1'b0;

        // nominal frames: lock at start of the second frame
        clear_stats();
        nominal(0);
        check("f0_locked", 32'(locked_out), 0);
        check("f0_act", act_cnt, 0);
        check("f0_fs", fs_cnt, 0);
        clear_stats();
        nominal(1);
        check("f1_rise_cnt", rise_cnt, 1);
        check("f1_rise_line", rise_l, 0);
        check("f1_rise_pix", rise_p, 1);
        check("f1_act", act_cnt, H_D * V_D);
        check("f1_fs", fs_cnt, 1);
        for (int f = 2; f < 4; f++) begin
            clear_stats();
            nominal(1);
            check("fn_act", act_cnt, H_D * V_D);
            check("fn_fs", fs_cnt, 1);
            check("fn_err", err_cnt, 0);
            check("fn_locked", 32'(locked_out), 1);
            check("fn_first_x", first_x, 0);
            check("fn_first_y", first_y, 0);
            check("fn_last_x", last_x, H_D - 1);
            check("fn_last_y", last_y, V_D - 1);
        end

        // random line lengths within tolerance keep lock
        for (int f = 0; f < 2; f++) begin
            clear_stats();
            send_frame(V_T, 1, -1, 0, 1, -1, 0);
            check("rnd_act", act_cnt, H_D * V_D);
            check("rnd_err", err_cnt, 0);
            check("rnd_locked", 32'(locked_out), 1);
        end

        // hsync absent while locked
        nominal(1);
        clear_stats();
        g0 = cyc;
        for (int g = 0; g < 1100; g++) step(1'b1, 1'b1, 0, 0, 0, 0);
        check("gap_err_cnt", err_cnt, 1);
        check("gap_err_time", err_cyc - g0, 1027 - last_len);
        check("gap_locked", 32'(locked_out), 0);
        clear_stats();
        nominal(0);
        nominal(1);
        check("relock_act", act_cnt, H_D * V_D);
        check("relock_locked", 32'(locked_out), 1);

        // short frame while locked
        clear_stats();
        send_frame(V_T - 3, 0, -1, 0, 0, -1, 0);
        check("short_fs_prev", fs_cnt, 1);
        check("short_err_prev", err_cnt, 0);
        clear_stats();
        nominal(0);
        check("short_err", err_cnt, 1);
        check("short_fs", fs_cnt, 0);
        check("short_locked", 32'(locked_out), 0);

        // long-but-legal lines, then one bad line
        do_reset();
        base_len = H_T + TOL;
        nominal(0);
        nominal(1);
        clear_stats();
        nominal(1);
        check("long_act", act_cnt, H_D * V_D);
        check("long_locked", 32'(locked_out), 1);
        clear_stats();
        bad_len = int'($urandom_range(37, 20));
        send_frame(V_T, 0, 8, bad_len, 0, -1, 0);
        check("bad_err", err_cnt, 1);
        check("bad_fs", fs_cnt, 1);
        check("bad_locked", 32'(locked_out), 0);
        clear_stats();
        nominal(1);
        check("bad_relock_rise", rise_cnt, 1);
        check("bad_relock_act", act_cnt, H_D * V_D);
        check("bad_relock_locked", 32'(locked_out), 1);

        // asynchronous reset mid-line while locked
        base_len = H_T;
        nominal(1);
        clear_stats();
        rst_p = int'($urandom_range(30, 14));
        send_frame(V_T, 1, -1, 0, 0, 8, rst_p);
        check("mid_rise", rise_cnt, 0);
        check("mid_locked", 32'(locked_out), 0);
        clear_stats();
        nominal(1);
        check("mid_relock_rise", rise_cnt, 1);
        check("mid_relock_act", act_cnt, H_D * V_D);
        check("mid_relock_locked", 32'(locked_out), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
